// File: rtl/motor_pkg.sv
// Phase-code constants, decoder state and code-to-index lookup shared by motor_driver and motor_phase_decoder.
// MOTOR_PHASE_DECODER_HALFSTEP_EN selects the 8-state half-step sequence instead of 4-state full-step.
package motor_pkg;

  localparam int unsigned PHASE_W = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned POS_W   = 32;

  localparam logic [PHASE_W-1:0] PH_IDLE = 4'b0000;

  // Full-step sequence, indices 0..3
  localparam logic [PHASE_W-1:0] PH_FS0 = 4'b0001;
  localparam logic [PHASE_W-1:0] PH_FS1 = 4'b0010;
  localparam logic [PHASE_W-1:0] PH_FS2 = 4'b0100;
  localparam logic [PHASE_W-1:0] PH_FS3 = 4'b1000;

  // Half-step sequence, indices 0..7
  localparam logic [PHASE_W-1:0] PH_HS0 = 4'b0001;
  localparam logic [PHASE_W-1:0] PH_HS1 = 4'b0011;
  localparam logic [PHASE_W-1:0] PH_HS2 = 4'b0010;
  localparam logic [PHASE_W-1:0] PH_HS3 = 4'b0110;
  localparam logic [PHASE_W-1:0] PH_HS4 = 4'b0100;
  localparam logic [PHASE_W-1:0] PH_HS5 = 4'b1100;
  localparam logic [PHASE_W-1:0] PH_HS6 = 4'b1000;
  localparam logic [PHASE_W-1:0] PH_HS7 = 4'b1001;

`ifdef MOTOR_PHASE_DECODER_HALFSTEP_EN
  localparam int unsigned N_STATES = 8;
`else
  localparam int unsigned N_STATES = 4;
`endif

  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(N_STATES - 1);

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } dec_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
  } phase_idx_t;

  // Maps a coil code to its sequence position; PH_IDLE and illegal codes return valid=0.
  function automatic phase_idx_t code_to_index(input logic [PHASE_W-1:0] code);
    phase_idx_t r;
    r.valid = 1'b0;
    r.index = '0;
    case (code)
`ifdef MOTOR_PHASE_DECODER_HALFSTEP_EN
      PH_HS0: begin r.valid = 1'b1; r.index = 3'd0; end
      PH_HS1: begin r.valid = 1'b1; r.index = 3'd1; end
      PH_HS2: begin r.valid = 1'b1; r.index = 3'd2; end
      PH_HS3: begin r.valid = 1'b1; r.index = 3'd3; end
      PH_HS4: begin r.valid = 1'b1; r.index = 3'd4; end
      PH_HS5: begin r.valid = 1'b1; r.index = 3'd5; end
      PH_HS6: begin r.valid = 1'b1; r.index = 3'd6; end
      PH_HS7: begin r.valid = 1'b1; r.index = 3'd7; end
`else
      PH_FS0: begin r.valid = 1'b1; r.index = 3'd0; end
      PH_FS1: begin r.valid = 1'b1; r.index = 3'd1; end
      PH_FS2: begin r.valid = 1'b1; r.index = 3'd2; end
      PH_FS3: begin r.valid = 1'b1; r.index = 3'd3; end
`endif
      default: begin
        r.valid = 1'b0;
        r.index = '0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/motor_phase_filter.sv
// Two-flop synchronizer plus stability filter for the coil-phase bus.
// Emits the accepted code and a one-cycle new_code strobe when a stable, different code appears.
module motor_phase_filter
  import motor_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] code,
  output logic               new_code
);

  localparam int unsigned         CNT_W   = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0]    RUN_MAX = CNT_W'(FILTER_CYCLES);

  logic [PHASE_W-1:0] sync1_q, sync1_d;
  logic [PHASE_W-1:0] sync2_q, sync2_d;
  logic [PHASE_W-1:0] prev_q,  prev_d;
  logic [CNT_W-1:0]   run_q,   run_d;
  logic [PHASE_W-1:0] code_q,  code_d;
  logic               new_code_q, new_code_d;

  // run_d counts the current cycle, so a code is taken on its FILTER_CYCLES-th stable cycle
  always_comb begin
    sync1_d    = phase;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    code_d     = code_q;
    new_code_d = 1'b0;

    if (sync2_q != prev_q) begin
      run_d = CNT_W'(1);
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + CNT_W'(1);
    end else begin
      run_d = run_q;
    end

    if ((run_d == RUN_MAX) && (sync2_q != code_q)) begin
      code_d     = sync2_q;
      new_code_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      run_q      <= '0;
      code_q     <= '0;
      new_code_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      code_q     <= code_d;
      new_code_q <= new_code_d;
    end
  end

  assign code     = code_q;
  assign new_code = new_code_q;

endmodule

// File: rtl/motor_phase_decoder.sv
// Reconstructs step position, direction, period and error flags from the motor_driver coil-phase bus.
// Define MOTOR_PHASE_DECODER_HALFSTEP_EN to decode the 8-state half-step sequence.
module motor_phase_decoder
  import motor_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 2,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          phase,
  input  logic                clear,
  output logic [31:0]         position,
  output logic                dir,
  output logic                step_pulse,
  output logic [PERIOD_W-1:0] step_period,
  output logic                locked,
  output logic                skip_err,
  output logic                code_err
);

  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  logic [PHASE_W-1:0] acc_code;
  logic               new_code;
  phase_idx_t         dec;

  dec_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [POS_W-1:0]   position_q, position_d;
  logic               dir_q, dir_d;
  logic               step_pulse_q, step_pulse_d;
  logic [PERIOD_W-1:0] step_period_q, step_period_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic               locked_q, locked_d;
  logic               skip_err_q, skip_err_d;
  logic               code_err_q, code_err_d;
  logic [IDX_W-1:0]   idx_fwd, idx_rev;

  motor_phase_filter #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .phase    (phase),
    .code     (acc_code),
    .new_code (new_code)
  );

  assign dec     = code_to_index(acc_code);
  assign idx_fwd = (idx_q + IDX_W'(1)) & IDX_MASK;
  assign idx_rev = (idx_q - IDX_W'(1)) & IDX_MASK;

  // clear is applied first so a same-cycle step or error lands on top of it
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dir_d         = dir_q;
    step_pulse_d  = 1'b0;
    step_period_d = step_period_q;
    locked_d      = locked_q;
    position_d    = clear ? '0   : position_q;
    skip_err_d    = clear ? 1'b0 : skip_err_q;
    code_err_d    = clear ? 1'b0 : code_err_q;
    per_cnt_d     = (per_cnt_q == PERIOD_MAX) ? per_cnt_q : per_cnt_q + PERIOD_W'(1);

    if (new_code && (acc_code != PH_IDLE)) begin
      if (!dec.valid) begin
        code_err_d = 1'b1;
      end else begin
        case (state_q)
          ACQUIRE: begin
            idx_d     = dec.index;
            state_d   = TRACK;
            locked_d  = 1'b1;
            per_cnt_d = PERIOD_W'(1);
          end
          TRACK: begin
            idx_d = dec.index;
            if (dec.index == idx_fwd) begin
              position_d    = position_d + 32'd1;
              dir_d         = 1'b1;
              step_pulse_d  = 1'b1;
              step_period_d = per_cnt_q;
              per_cnt_d     = PERIOD_W'(1);
            end else if (dec.index == idx_rev) begin
              position_d    = position_d - 32'd1;
              dir_d         = 1'b0;
              step_pulse_d  = 1'b1;
              step_period_d = per_cnt_q;
              per_cnt_d     = PERIOD_W'(1);
            end else begin
              skip_err_d = 1'b1;
            end
          end
          default: state_d = ACQUIRE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ACQUIRE;
      idx_q         <= '0;
      position_q    <= '0;
      dir_q         <= 1'b1;
      step_pulse_q  <= 1'b0;
      step_period_q <= '0;
      per_cnt_q     <= '0;
      locked_q      <= 1'b0;
      skip_err_q    <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      position_q    <= position_d;
      dir_q         <= dir_d;
      step_pulse_q  <= step_pulse_d;
      step_period_q <= step_period_d;
      per_cnt_q     <= per_cnt_d;
      locked_q      <= locked_d;
      skip_err_q    <= skip_err_d;
      code_err_q    <= code_err_d;
    end
  end

  assign position    = position_q;
  assign dir         = dir_q;
  assign step_pulse  = step_pulse_q;
  assign step_period = step_period_q;
  assign locked      = locked_q;
  assign skip_err    = skip_err_q;
  assign code_err    = code_err_q;

endmodule

// File: tb/tb_motor_phase_decoder.sv
// Self-checking bench for motor_phase_decoder against an event-level reference model.
// Honours MOTOR_PHASE_DECODER_HALFSTEP_EN so the model follows whichever sequence the DUT decodes.
module tb_motor_phase_decoder;

  localparam int FC = 2;
  localparam int PW = 24;

`ifdef MOTOR_PHASE_DECODER_HALFSTEP_EN
  localparam int N = 8;
  logic [3:0] seq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
  localparam int N = 4;
  logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [3:0]    phase;
  logic [31:0]   position;
  logic          dir;
  logic          step_pulse;
  logic [PW-1:0] step_period;
  logic          locked;
  logic          skip_err;
  logic          code_err;

  motor_phase_decoder #(
    .FILTER_CYCLES (FC),
    .PERIOD_W      (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .phase       (phase),
    .clear       (clear),
    .position    (position),
    .dir         (dir),
    .step_pulse  (step_pulse),
    .step_period (step_period),
    .locked      (locked),
    .skip_err    (skip_err),
    .code_err    (code_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;

  always @(negedge clk) if (step_pulse === 1'b1) pulses++;

  // Reference model: reacts to whole input events (code + hold length + start cycle)
  bit            m_locked;
  int            m_idx;
  logic [31:0]   m_pos;
  bit            m_dir;
  bit            m_skip;
  bit            m_cerr;
  logic [3:0]    m_last;
  int            m_tev;
  int            m_pulses = 0;
  logic [PW-1:0] m_period;

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < N; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_idx = 0; m_pos = '0; m_dir = 1; m_skip = 0; m_cerr = 0;
    m_last = 4'b0000; m_tev = 0; m_period = '0;
  endtask

  task automatic model_apply(input logic [3:0] c, input int hold, input int t);
    int idx;
    int diff;
    if (hold < FC) return;
    if (c == m_last) return;
    m_last = c;
    if (c == 4'b0000) return;
    idx = lookup(c);
    if (idx < 0) begin
      m_cerr = 1;
      return;
    end
    if (!m_locked) begin
      m_locked = 1; m_idx = idx; m_tev = t;
      return;
    end
    diff = (idx - m_idx + N) % N;
    if (diff == 1 || diff == N - 1) begin
      m_pos    = (diff == 1) ? m_pos + 32'd1 : m_pos - 32'd1;
      m_dir    = (diff == 1);
      m_pulses = m_pulses + 1;
      m_period = ((t - m_tev) > (2**PW - 1)) ? '1 : PW'(t - m_tev);
      m_tev    = t;
    end else begin
      m_skip = 1;
    end
    m_idx = idx;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input int hold);
    phase = c;
    model_apply(c, hold, cyc);
    tick(hold);
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; phase = 4'b0000;
    tick(2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (position !== 32'd0)   begin failures++; $display("FAIL rst_position: got %h want 0", position); end
    if (dir !== 1'b1)         begin failures++; $display("FAIL rst_dir: got %b want 1", dir); end
    if (step_pulse !== 1'b0)  begin failures++; $display("FAIL rst_pulse: got %b want 0", step_pulse); end
    if (step_period !== '0)   begin failures++; $display("FAIL rst_period: got %0d want 0", step_period); end
    if (locked !== 1'b0)      begin failures++; $display("FAIL rst_locked: got %b want 0", locked); end
    if (skip_err !== 1'b0)    begin failures++; $display("FAIL rst_skip: got %b want 0", skip_err); end
    if (code_err !== 1'b0)    begin failures++; $display("FAIL rst_code: got %b want 0", code_err); end
  endtask

  task automatic test_forward();
    logic [31:0] pos_before;
    logic [3:0]  c;
    do_reset();
    drive(seq[0], 10);
    for (int k = 1; k < 4; k++) drive(seq[k % N], 10);
    // Last step doubles as the latency check
    c = seq[4 % N];
    pos_before = m_pos;
    phase = c;
    model_apply(c, 10, cyc);
    tick(FC + 2);
    checks++;
    if (position !== pos_before) begin failures++; $display("FAIL lat_early: got %h want %h", position, pos_before); end
    tick(1);
    checks++;
    if (position !== m_pos) begin failures++; $display("FAIL lat_edge: got %h want %h", position, m_pos); end
    tick(10 - FC - 3);
    checks += 5;
    if (locked !== 1'b1)       begin failures++; $display("FAIL fwd_locked: got %b want 1", locked); end
    if (pulses !== m_pulses)   begin failures++; $display("FAIL fwd_pulses: got %0d want %0d", pulses, m_pulses); end
    if (position !== m_pos)    begin failures++; $display("FAIL fwd_position: got %h want %h", position, m_pos); end
    if (dir !== m_dir)         begin failures++; $display("FAIL fwd_dir: got %b want %b", dir, m_dir); end
    if (step_period !== m_period) begin failures++; $display("FAIL fwd_period: got %0d want %0d", step_period, m_period); end
  endtask

  task automatic test_reverse_wrap();
    do_reset();
    drive(seq[0], 10);
    for (int k = 1; k <= 3; k++) drive(seq[(N - k) % N], 10);
    checks += 2;
    if (position !== m_pos) begin failures++; $display("FAIL rev_position: got %h want %h", position, m_pos); end
    if (dir !== m_dir)      begin failures++; $display("FAIL rev_dir: got %b want %b", dir, m_dir); end
    force dut.position_q = 32'h7FFF_FFFF;
    tick(1);
    release dut.position_q;
    m_pos = 32'h7FFF_FFFF;
    drive(seq[(N - 2) % N], 10);
    checks += 2;
    if (position !== m_pos) begin failures++; $display("FAIL wrap_position: got %h want %h", position, m_pos); end
    if (dir !== m_dir)      begin failures++; $display("FAIL wrap_dir: got %b want %b", dir, m_dir); end
  endtask

  task automatic test_glitch();
    logic [3:0] cur;
    logic [3:0] nxt;
    cur = seq[m_idx];
    nxt = seq[(m_idx + 1) % N];
    phase = nxt;
    model_apply(nxt, 1, cyc);
    tick(1);
    drive(cur, 10);
    checks += 2;
    if (pulses !== m_pulses) begin failures++; $display("FAIL glitch_pulses: got %0d want %0d", pulses, m_pulses); end
    if (position !== m_pos)  begin failures++; $display("FAIL glitch_position: got %h want %h", position, m_pos); end
  endtask

  task automatic test_skip_illegal();
    do_reset();
    drive(4'b0001, 10);
    drive(4'b0100, 10);
    checks += 3;
    if (skip_err !== m_skip) begin failures++; $display("FAIL skip_flag: got %b want %b", skip_err, m_skip); end
    if (position !== m_pos)  begin failures++; $display("FAIL skip_position: got %h want %h", position, m_pos); end
    if (pulses !== m_pulses) begin failures++; $display("FAIL skip_pulses: got %0d want %0d", pulses, m_pulses); end
    drive(4'b0110, 10);
    checks += 2;
    if (code_err !== m_cerr) begin failures++; $display("FAIL illegal_flag: got %b want %b", code_err, m_cerr); end
    if (position !== m_pos)  begin failures++; $display("FAIL illegal_position: got %h want %h", position, m_pos); end
    drive(seq[(m_idx + 1) % N], 10);
    checks += 2;
    if (position !== m_pos) begin failures++; $display("FAIL illegal_idx_kept: got %h want %h", position, m_pos); end
    if (dir !== m_dir)      begin failures++; $display("FAIL illegal_dir: got %b want %b", dir, m_dir); end
    clear = 1'b1;
    m_pos = '0; m_skip = 0; m_cerr = 0;
    tick(1);
    clear = 1'b0;
    checks += 3;
    if (position !== m_pos)  begin failures++; $display("FAIL clear_position: got %h want %h", position, m_pos); end
    if (skip_err !== m_skip) begin failures++; $display("FAIL clear_skip: got %b want %b", skip_err, m_skip); end
    if (code_err !== m_cerr) begin failures++; $display("FAIL clear_code: got %b want %b", code_err, m_cerr); end
  endtask

  // Raises clear exactly on the edge where the code's effect lands
  task automatic drive_with_clear(input logic [3:0] c);
    int t0;
    t0 = cyc;
    phase = c;
    tick(FC + 2);
    clear = 1'b1;
    m_pos = '0; m_skip = 0; m_cerr = 0;
    model_apply(c, 10, t0);
    tick(1);
    clear = 1'b0;
    tick(10 - FC - 3);
  endtask

  task automatic test_clear_with_step();
    do_reset();
    drive(seq[0], 10);
    for (int k = 1; k <= 7; k++) drive(seq[k % N], 8);
    checks++;
    if (position !== m_pos) begin failures++; $display("FAIL pre_clear_position: got %h want %h", position, m_pos); end
    drive_with_clear(seq[(m_idx + 1) % N]);
    checks += 2;
    if (position !== m_pos)  begin failures++; $display("FAIL clrstep_position: got %h want %h", position, m_pos); end
    if (pulses !== m_pulses) begin failures++; $display("FAIL clrstep_pulses: got %0d want %0d", pulses, m_pulses); end
    drive_with_clear(seq[(m_idx + 2) % N]);
    checks += 2;
    if (skip_err !== m_skip) begin failures++; $display("FAIL clrerr_skip: got %b want %b", skip_err, m_skip); end
    if (position !== m_pos)  begin failures++; $display("FAIL clrerr_position: got %h want %h", position, m_pos); end
  endtask

  task automatic test_walk_and_reset();
    do_reset();
    drive(seq[0], 10);
    for (int k = 1; k <= N; k++) drive(seq[k % N], 10);
    checks += 4;
    if (pulses !== m_pulses) begin failures++; $display("FAIL walk_pulses: got %0d want %0d", pulses, m_pulses); end
    if (position !== m_pos)  begin failures++; $display("FAIL walk_position: got %h want %h", position, m_pos); end
    if (skip_err !== 1'b0)   begin failures++; $display("FAIL walk_skip: got %b want 0", skip_err); end
    if (code_err !== 1'b0)   begin failures++; $display("FAIL walk_code: got %b want 0", code_err); end
    phase = seq[1];
    tick(2);
    reset = 1'b1;
    tick(1);
    checks += 6;
    if (position !== 32'd0)  begin failures++; $display("FAIL midrst_position: got %h want 0", position); end
    if (dir !== 1'b1)        begin failures++; $display("FAIL midrst_dir: got %b want 1", dir); end
    if (step_pulse !== 1'b0) begin failures++; $display("FAIL midrst_pulse: got %b want 0", step_pulse); end
    if (step_period !== '0)  begin failures++; $display("FAIL midrst_period: got %0d want 0", step_period); end
    if (locked !== 1'b0)     begin failures++; $display("FAIL midrst_locked: got %b want 0", locked); end
    if ((skip_err | code_err) !== 1'b0) begin failures++; $display("FAIL midrst_errs: got %b%b want 00", skip_err, code_err); end
    phase = 4'b0000;
    tick(1);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic [3:0] prev;
    int r;
    int hold;
    do_reset();
    prev = 4'b0000;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55 && m_locked)
        c = ($urandom_range(0, 1) == 1) ? seq[(m_idx + 1) % N] : seq[(m_idx + N - 1) % N];
      else if (r < 70)
        c = seq[$urandom_range(0, N - 1)];
      else if (r < 80)
        c = 4'b0000;
      else
        c = 4'($urandom_range(0, 15));
      while (c == prev) c = 4'($urandom_range(0, 15));
      prev = c;
      if ($urandom_range(0, 99) < 20 && FC > 1) hold = $urandom_range(1, FC - 1);
      else hold = $urandom_range(FC, 12);
      drive(c, hold);
      if (hold >= FC + 4) begin
        checks += 7;
        if (position !== m_pos)       begin failures++; $display("FAIL rnd_position it=%0d: got %h want %h", it, position, m_pos); end
        if (dir !== m_dir)            begin failures++; $display("FAIL rnd_dir it=%0d: got %b want %b", it, dir, m_dir); end
        if (step_period !== m_period) begin failures++; $display("FAIL rnd_period it=%0d: got %0d want %0d", it, step_period, m_period); end
        if (locked !== m_locked)      begin failures++; $display("FAIL rnd_locked it=%0d: got %b want %b", it, locked, m_locked); end
        if (skip_err !== m_skip)      begin failures++; $display("FAIL rnd_skip it=%0d: got %b want %b", it, skip_err, m_skip); end
        if (code_err !== m_cerr)      begin failures++; $display("FAIL rnd_code it=%0d: got %b want %b", it, code_err, m_cerr); end
        if (pulses !== m_pulses)      begin failures++; $display("FAIL rnd_pulses it=%0d: got %0d want %0d", it, pulses, m_pulses); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    phase = 4'b0000;
    model_reset();
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_glitch();
    test_skip_illegal();
    test_clear_with_step();
    test_walk_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
